power_result_poller: RTL and testbench



---
 rtl/power_emu_pkg.sv | 32 +++
 rtl/power_sample_fifo.sv | 68 ++++++
 rtl/power_result_poller.sv | 146 ++++++++++++++
 tb/tb_power_result_poller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/power_emu_pkg.sv
// =============================================================================
// Package : power_emu_pkg
// Brief   : Shared types and register map for the power emulator result poller.
// Rev     : 1.0
// =============================================================================
`default_nettype none

package power_emu_pkg;

    localparam int RES_W_DEF = 36;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_RES_LO = 2'd2;
    localparam logic [1:0] ADDR_RES_HI = 2'd3;

    localparam int CTRL_START = 0;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        START_WR = 4'd1,
        WAIT     = 4'd2,
        RD_LO    = 4'd3,
        CAP_LO   = 4'd4,
        RD_HI    = 4'd5,
        CAP_HI   = 4'd6,
        CLR_WR   = 4'd7,
        PUSH     = 4'd8
    } poller_state_t;

endpackage

`default_nettype wire

// File: rtl/power_sample_fifo.sv
// =============================================================================
// Module : power_sample_fifo
// Brief  : Registered show-ahead FIFO; head entry is always visible on data.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module power_sample_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    assign empty = (r_count == '0);
    assign full  = (r_count == (PTR_W+1)'(DEPTH));
    assign data  = r_mem[r_rd_ptr];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/power_result_poller.sv
// =============================================================================
// Module : power_result_poller
// Brief  : Bus master that runs one emulator estimation per trig and queues results.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module power_result_poller
    import power_emu_pkg::*;
#(
    parameter int RES_W       = RES_W_DEF,
    parameter int WAIT_CYCLES = 64,
    parameter int DEPTH       = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             trig,
    output logic             busy,
    output logic             m_read,
    output logic             m_write,
    output logic [1:0]       m_addr,
    output logic [31:0]      m_wdata,
    input  logic [31:0]      m_rdata,
    output logic             smp_valid,
    input  logic             smp_ready,
    output logic [RES_W-1:0] smp_data,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam int HI_W  = RES_W - 32;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    poller_state_t    r_state;
    poller_state_t    w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_lo;
    logic [HI_W-1:0]  r_hi;
    logic             r_ovf;

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic w_drop;

    assign busy      = (r_state != IDLE);
    assign smp_valid = !w_empty;
    assign ovf       = r_ovf;

    assign w_push = (r_state == PUSH);
    assign w_pop  = smp_valid && smp_ready;
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                START_WR: r_cnt <= CNT_W'(WAIT_CYCLES - 1);
                WAIT:     if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                CAP_LO:   r_lo  <= m_rdata;
                CAP_HI:   r_hi  <= m_rdata[HI_W-1:0];
                default:  ;
            endcase
            // A new overflow takes priority over a simultaneous clear.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        m_read      = 1'b0;
        m_write     = 1'b0;
        m_addr      = 2'd0;
        m_wdata     = 32'd0;
        case (r_state)
            IDLE: begin
                if (trig) w_state_nxt = START_WR;
            end
            START_WR: begin
                m_write     = 1'b1;
                m_addr      = ADDR_CTRL;
                m_wdata     = 32'h1 << CTRL_START;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (r_cnt == '0) w_state_nxt = RD_LO;
            end
            RD_LO: begin
                m_read      = 1'b1;
                m_addr      = ADDR_RES_LO;
                w_state_nxt = CAP_LO;
            end
            CAP_LO: begin
                w_state_nxt = RD_HI;
            end
            RD_HI: begin
                m_read      = 1'b1;
                m_addr      = ADDR_RES_HI;
                w_state_nxt = CAP_HI;
            end
            CAP_HI: begin
                w_state_nxt = CLR_WR;
            end
            CLR_WR: begin
                m_write     = 1'b1;
                m_addr      = ADDR_CTRL;
                m_wdata     = 32'd0;
                w_state_nxt = PUSH;
            end
            PUSH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    power_sample_fifo #(
        .WIDTH (RES_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data ({r_hi, r_lo}),
        .full      (w_full),
        .pop       (w_pop),
        .empty     (w_empty),
        .data      (smp_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_power_result_poller.sv
// =============================================================================
// Module : tb_power_result_poller
// Brief  : Scoreboard bench for power_result_poller with a one-cycle-latency slave.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module tb_power_result_poller;

    localparam int RES_W = 36;
    localparam int W     = 64;
    localparam int DEPTH = 4;

    logic             clk       = 1'b0;
    logic             reset_n   = 1'b0;
    logic             trig      = 1'b0;
    logic             smp_ready = 1'b0;
    logic             ovf_clr   = 1'b0;
    logic [31:0]      m_rdata   = 32'h0;
    logic             busy;
    logic             m_read;
    logic             m_write;
    logic [1:0]       m_addr;
    logic [31:0]      m_wdata;
    logic             smp_valid;
    logic [RES_W-1:0] smp_data;
    logic             ovf;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    logic [31:0] slv_lo   = 32'h0;
    logic [31:0] slv_hi   = 32'h0;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
    } ev_t;

    ev_t              evq[$];
    logic [RES_W-1:0] sb[$];

    power_result_poller #(
        .RES_W       (RES_W),
        .WAIT_CYCLES (W),
        .DEPTH       (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .trig      (trig),
        .busy      (busy),
        .m_read    (m_read),
        .m_write   (m_write),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .smp_data  (smp_data),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Slave: data valid one cycle after m_read, junk otherwise.
    always @(posedge clk) begin
        if (m_read)
            m_rdata <= (m_addr == 2'd2) ? slv_lo : (m_addr == 2'd3) ? slv_hi : 32'h0;
        else
            m_rdata <= 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (m_read || m_write) begin
                check_val("strobe_excl", 64'(m_read && m_write), 64'd0);
                evq.push_back('{cyc, m_write, m_addr, m_wdata});
            end else begin
                check_val("idle_bus", 64'({m_addr, m_wdata}), 64'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && smp_valid && smp_ready) begin
            if (sb.size() == 0)
                check_val("sb_underflow", 64'd1, 64'd0);
            else
                check_val("smp_data", 64'(smp_data), 64'(sb.pop_front()));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_ev(input int i, input int ecyc, input logic ewr,
                            input logic [1:0] eaddr, input logic [31:0] edata);
        check_val($sformatf("ev%0d_cyc", i), 64'(evq[i].cyc), 64'(ecyc));
        check_val($sformatf("ev%0d_kind", i), {61'd0, evq[i].wr, evq[i].addr},
                  {61'd0, ewr, eaddr});
        if (ewr) check_val($sformatf("ev%0d_wdata", i), 64'(evq[i].data), 64'(edata));
    endtask

    task automatic run_meas(input logic [31:0] lo, input logic [31:0] hi, input bit exp_push,
                            input int retrig_at, input bit ready_at_push,
                            input bit clr_at_push, input bit chk_rise);
        int t;
        logic [RES_W-1:0] exp_res;
        slv_lo  = lo;
        slv_hi  = hi;
        exp_res = {hi[RES_W-33:0], lo};
        evq.delete();
        if (exp_push) sb.push_back(exp_res);
        trig = 1'b1;
        t    = cyc;
        tick();
        for (int k = 1; k <= W + 7; k++) begin
            trig      = (k == retrig_at);
            smp_ready = ready_at_push && (k == W + 7);
            ovf_clr   = clr_at_push && (k == W + 7);
            if (chk_rise && k == W + 7) check_val("valid_before_push", 64'(smp_valid), 64'd0);
            tick();
        end
        trig      = 1'b0;
        smp_ready = 1'b0;
        ovf_clr   = 1'b0;
        check_val("busy_done", 64'(busy), 64'd0);
        if (chk_rise) begin
            check_val("valid_rise", 64'(smp_valid), 64'd1);
            check_val("head_data", 64'(smp_data), 64'(exp_res));
        end
        check_val("n_txn", 64'(evq.size()), 64'd4);
        if (evq.size() == 4) begin
            check_ev(0, t + 1,     1'b1, 2'd0, 32'h1);
            check_ev(1, t + W + 2, 1'b0, 2'd2, 32'h0);
            check_ev(2, t + W + 4, 1'b0, 2'd3, 32'h0);
            check_ev(3, t + W + 6, 1'b1, 2'd0, 32'h0);
        end
    endtask

    task automatic drain(input int n, input int exp_left);
        smp_ready = 1'b1;
        repeat (n) tick();
        smp_ready = 1'b0;
        check_val("sb_left", 64'(sb.size()), 64'(exp_left));
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_strobes"}, 64'({m_read, m_write}), 64'd0);
        check_val({tag, "_addr_wdata"}, 64'({m_addr, m_wdata}), 64'd0);
        check_val({tag, "_valid"}, 64'(smp_valid), 64'd0);
        check_val({tag, "_ovf"}, 64'(ovf), 64'd0);
    endtask

    initial begin
        int t;
        // Reset and idle
        repeat (3) tick();
        check_quiet("in_reset");
        reset_n = 1'b1;
        repeat (20) tick();
        check_quiet("idle");
        check_val("idle_txn", 64'(evq.size()), 64'd0);

        // Single measurement with an ignored retrigger while busy
        run_meas(32'hFFFF_FFFF, 32'h1111_1111, 1'b1, 10, 1'b0, 1'b0, 1'b1);
        repeat (W + 10) tick();
        check_val("no_retrig_txn", 64'(evq.size()), 64'd4);
        drain(1, 0);
        check_val("empty_after_one", 64'(smp_valid), 64'd0);

        // Fill the FIFO, then drop a fifth sample while clearing ovf in the same cycle
        for (int k = 1; k <= 4; k++)
            run_meas(32'h1000_0000 * k + k, 32'hABCD_EF00 | k, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        check_val("ovf_not_yet", 64'(ovf), 64'd0);
        run_meas(32'h5555_5555, 32'h5, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        check_val("ovf_set_wins", 64'(ovf), 64'd1);
        check_val("full_valid", 64'(smp_valid), 64'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_val("ovf_cleared", 64'(ovf), 64'd0);

        // Full FIFO with a pop in the PUSH cycle: no overflow, order preserved
        run_meas(32'h6666_6666, 32'hFFFF_FFF6, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        check_val("ovf_pop_push", 64'(ovf), 64'd0);
        drain(3, 1);
        check_val("one_left_valid", 64'(smp_valid), 64'd1);

        // Reset during WAIT aborts the transaction and empties the FIFO
        evq.delete();
        slv_lo = 32'h7777_7777;
        slv_hi = 32'h7;
        trig   = 1'b1;
        t      = cyc;
        tick();
        trig = 1'b0;
        while (cyc < t + 20) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        sb.delete();
        check_quiet("after_abort");
        repeat (W + 10) tick();
        check_val("abort_no_clear", 64'(evq.size()), 64'd1);
        run_meas(32'h8765_4321, 32'h0000_000A, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        drain(1, 0);
        check_val("final_empty", 64'(smp_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
